// File: rtl/pkt_admit_ctrl_pkg.sv
// Shared definitions for the packet word format and the admission FSM.
// The cache and the downstream stages import the same package.
package pkt_admit_ctrl_pkg;

    localparam int WORD_W  = 134;
    localparam int ID_W    = 8;
    localparam int IDCNT_W = 5;

    // Field positions inside a 134-bit packet word
    localparam int FLAG_HI = 133;
    localparam int FLAG_LO = 132;
    localparam int INV_HI  = 131;
    localparam int INV_LO  = 128;

    localparam int WORD_BYTES_LOG2 = 4;

    typedef enum logic [1:0] {
        FLAG_BAD  = 2'b00,
        FLAG_HEAD = 2'b01,
        FLAG_TAIL = 2'b10,
        FLAG_MID  = 2'b11
    } flag_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS  = 2'd1,
        ST_DROP  = 2'd2,
        ST_TRUNC = 2'd3
    } state_e;

    function automatic flag_e word_flag(input logic [WORD_W-1:0] word);
        return flag_e'(word[FLAG_HI:FLAG_LO]);
    endfunction

endpackage

// File: rtl/pkt_admit_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && !(&count_q)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pkt_admit_ctrl.sv
// Admission stage in front of the packet data cache: forwards packets that get a buffer ID,
// commits or discards them at the tail, and counts drops and framing errors.
module pkt_admit_ctrl
    import pkt_admit_ctrl_pkg::*;
#(
    parameter int MAX_WORDS = 128,
    parameter int LEN_W     = 12,
    parameter int CNT_W     = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_pkt_data_wr,
    input  logic [WORD_W-1:0]       in_pkt_data,
    input  logic [ID_W-1:0]         in_cache_ID,
    input  logic [IDCNT_W-1:0]      in_cache_ID_count,
    output logic                    out_cache_data_wr,
    output logic [WORD_W-1:0]       out_cache_data,
    output logic                    out_cache_valid_wr,
    output logic                    out_cache_valid,
    output logic                    out_desc_wr,
    output logic [ID_W+LEN_W-1:0]   out_desc,
    output logic [CNT_W-1:0]        out_drop_noid_cnt,
    output logic [CNT_W-1:0]        out_drop_long_cnt,
    output logic [CNT_W-1:0]        out_err_fmt_cnt
);

    localparam int                WCNT_W   = $clog2(MAX_WORDS + 1);
    localparam int                DESC_W   = ID_W + LEN_W;
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MAX_WORDS);

    state_e              state_q,   state_d;
    logic [WCNT_W-1:0]   wcnt_q,    wcnt_d;
    logic [1:0]          pend_q,    pend_d;
    logic                data_wr_q, data_wr_d;
    logic [WORD_W-1:0]   data_q,    data_d;
    logic                vld_wr_q,  vld_wr_d;
    logic                vld_q,     vld_d;
    logic                desc_wr_q, desc_wr_d;
    logic [DESC_W-1:0]   desc_q,    desc_d;

    logic                noid_inc;
    logic                long_inc;
    logic                fmt_inc;
    flag_e               flag;
    logic                id_free;
    logic [LEN_W-1:0]    words_after;
    logic [LEN_W-1:0]    tail_len;

    assign flag = word_flag(in_pkt_data);

    // The cache lowers its free count a couple of cycles after a commit; hide that ID meanwhile.
    assign id_free = in_cache_ID_count > IDCNT_W'(pend_q != 2'd0);

    assign words_after = LEN_W'(wcnt_q) + LEN_W'(1);
    assign tail_len    = (words_after << WORD_BYTES_LOG2) - LEN_W'(in_pkt_data[INV_HI:INV_LO]);

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        pend_d    = (pend_q != 2'd0) ? pend_q - 2'd1 : 2'd0;
        data_wr_d = 1'b0;
        data_d    = data_q;
        vld_wr_d  = 1'b0;
        vld_d     = 1'b0;
        desc_wr_d = 1'b0;
        desc_d    = desc_q;
        noid_inc  = 1'b0;
        long_inc  = 1'b0;
        fmt_inc   = 1'b0;

        if (in_pkt_data_wr) begin
            if (flag == FLAG_BAD) begin
                fmt_inc = 1'b1;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (flag != FLAG_HEAD) begin
                            fmt_inc = 1'b1;
                        end else if (id_free) begin
                            data_wr_d = 1'b1;
                            data_d    = in_pkt_data;
                            wcnt_d    = WCNT_W'(1);
                            state_d   = ST_PASS;
                        end else begin
                            noid_inc = 1'b1;
                            state_d  = ST_DROP;
                        end
                    end
                    ST_PASS: begin
                        if (flag == FLAG_HEAD) begin
                            vld_wr_d = 1'b1;
                            fmt_inc  = 1'b1;
                            state_d  = ST_DROP;
                        end else if (wcnt_q == WCNT_MAX) begin
                            // Word MAX_WORDS+1 does not fit the slot; a tail here also ends the packet.
                            vld_wr_d = 1'b1;
                            long_inc = 1'b1;
                            state_d  = (flag == FLAG_TAIL) ? ST_IDLE : ST_TRUNC;
                        end else begin
                            data_wr_d = 1'b1;
                            data_d    = in_pkt_data;
                            wcnt_d    = wcnt_q + WCNT_W'(1);
                            if (flag == FLAG_TAIL) begin
                                vld_wr_d  = 1'b1;
                                vld_d     = 1'b1;
                                desc_wr_d = 1'b1;
                                desc_d    = {in_cache_ID, tail_len};
                                pend_d    = 2'd2;
                                state_d   = ST_IDLE;
                            end
                        end
                    end
                    ST_DROP, ST_TRUNC: begin
                        if (flag == FLAG_TAIL) begin
                            state_d = ST_IDLE;
                        end else if (flag == FLAG_HEAD) begin
                            fmt_inc = 1'b1;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            wcnt_q    <= '0;
            pend_q    <= '0;
            data_wr_q <= 1'b0;
            data_q    <= '0;
            vld_wr_q  <= 1'b0;
            vld_q     <= 1'b0;
            desc_wr_q <= 1'b0;
            desc_q    <= '0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            pend_q    <= pend_d;
            data_wr_q <= data_wr_d;
            data_q    <= data_d;
            vld_wr_q  <= vld_wr_d;
            vld_q     <= vld_d;
            desc_wr_q <= desc_wr_d;
            desc_q    <= desc_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_noid_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (noid_inc),
        .count (out_drop_noid_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_long_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (long_inc),
        .count (out_drop_long_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_fmt_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (fmt_inc),
        .count (out_err_fmt_cnt)
    );

    assign out_cache_data_wr  = data_wr_q;
    assign out_cache_data     = data_q;
    assign out_cache_valid_wr = vld_wr_q;
    assign out_cache_valid    = vld_q;
    assign out_desc_wr        = desc_wr_q;
    assign out_desc           = desc_q;

endmodule

// File: tb/tb_pkt_admit_ctrl.sv
// Scoreboard bench for pkt_admit_ctrl: directed cases plus random packet traffic
// checked against a packet-level reference model.
module tb_pkt_admit_ctrl;

    localparam int MAX_WORDS = 128;
    localparam int LEN_W     = 12;
    localparam int CNT_W     = 32;
    localparam logic [1:0] H = 2'b01;
    localparam logic [1:0] M = 2'b11;
    localparam logic [1:0] T = 2'b10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_pkt_data_wr = 1'b0;
    logic [133:0]      in_pkt_data = '0;
    logic [7:0]        in_cache_ID = '0;
    logic [4:0]        in_cache_ID_count = '0;
    logic              out_cache_data_wr;
    logic [133:0]      out_cache_data;
    logic              out_cache_valid_wr;
    logic              out_cache_valid;
    logic              out_desc_wr;
    logic [19:0]       out_desc;
    logic [CNT_W-1:0]  out_drop_noid_cnt;
    logic [CNT_W-1:0]  out_drop_long_cnt;
    logic [CNT_W-1:0]  out_err_fmt_cnt;

    pkt_admit_ctrl #(.MAX_WORDS(MAX_WORDS), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk                (clk),
        .rst                (rst),
        .in_pkt_data_wr     (in_pkt_data_wr),
        .in_pkt_data        (in_pkt_data),
        .in_cache_ID        (in_cache_ID),
        .in_cache_ID_count  (in_cache_ID_count),
        .out_cache_data_wr  (out_cache_data_wr),
        .out_cache_data     (out_cache_data),
        .out_cache_valid_wr (out_cache_valid_wr),
        .out_cache_valid    (out_cache_valid),
        .out_desc_wr        (out_desc_wr),
        .out_desc           (out_desc),
        .out_drop_noid_cnt  (out_drop_noid_cnt),
        .out_drop_long_cnt  (out_drop_long_cnt),
        .out_err_fmt_cnt    (out_err_fmt_cnt)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, exp, edge_n);
        end
    endtask

    // Expected events, stamped with the output cycle in which they must appear
    typedef struct { int stamp; logic [133:0] word; } wr_exp_t;
    typedef struct { int stamp; bit commit; logic [19:0] desc; } vld_exp_t;
    wr_exp_t  exp_wr[$];
    vld_exp_t exp_vld[$];

    // Reference model: one packet at a time, either being stored, being skipped, or none.
    bit m_open;
    bit m_skip;
    int m_words;
    int m_last_commit;
    int m_noid, m_long, m_fmt;

    task automatic model_reset();
        m_open = 0; m_skip = 0; m_words = 0; m_last_commit = -100;
        m_noid = 0; m_long = 0; m_fmt = 0;
    endtask

    task automatic model_word(input logic [133:0] w, input logic [4:0] cnt, input logic [7:0] id,
                              input int stamp);
        logic [1:0] f;
        int inv, pend, free;
        f   = w[133:132];
        inv = int'(w[131:128]);
        if (m_open) begin
            if (f == H) begin
                exp_vld.push_back(vld_exp_t'{stamp, 1'b0, 20'h0});
                m_fmt++; m_open = 0; m_skip = 1;
            end else if (m_words == MAX_WORDS) begin
                exp_vld.push_back(vld_exp_t'{stamp, 1'b0, 20'h0});
                m_long++; m_open = 0; m_skip = (f != T);
            end else begin
                exp_wr.push_back(wr_exp_t'{stamp, w});
                m_words++;
                if (f == T) begin
                    exp_vld.push_back(vld_exp_t'{stamp, 1'b1, {id, LEN_W'(m_words * 16 - inv)}});
                    m_last_commit = stamp;
                    m_open = 0;
                end
            end
        end else if (m_skip) begin
            if (f == T) m_skip = 0;
            else if (f == H) m_fmt++;
        end else if (f == H) begin
            // The committed ID stays counted in cnt for the two cycles after the commit strobe.
            pend = (stamp - m_last_commit >= 1 && stamp - m_last_commit <= 2) ? 1 : 0;
            free = int'(cnt) - pend;
            if (free < 0) free = 0;
            if (free > 0) begin
                exp_wr.push_back(wr_exp_t'{stamp, w});
                m_open = 1; m_words = 1;
            end else begin
                m_noid++; m_skip = 1;
            end
        end else begin
            m_fmt++;
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT strobes, or when an expected strobe is due
    int wr_seen = 0, commit_seen = 0, discard_seen = 0;
    logic [19:0] last_desc = '0;

    always @(negedge clk) begin
        bit want;
        if (edge_n > 0) begin
            want = exp_wr.size() > 0 && exp_wr[0].stamp == edge_n;
            if (out_cache_data_wr === 1'b1 || want) begin
                check("wr_strobe", out_cache_data_wr, want);
                if (want && out_cache_data_wr === 1'b1) check("wr_data", out_cache_data, exp_wr[0].word);
                if (want) void'(exp_wr.pop_front());
            end
            if (out_cache_data_wr === 1'b1) wr_seen++;

            want = exp_vld.size() > 0 && exp_vld[0].stamp == edge_n;
            if (out_cache_valid_wr === 1'b1 || want) begin
                check("vld_strobe", out_cache_valid_wr, want);
                if (want && out_cache_valid_wr === 1'b1) begin
                    check("vld_commit", out_cache_valid, exp_vld[0].commit);
                    check("desc_strobe", out_desc_wr, exp_vld[0].commit);
                    if (exp_vld[0].commit) check("desc_value", out_desc, exp_vld[0].desc);
                end
                if (want) void'(exp_vld.pop_front());
            end else if (out_desc_wr === 1'b1) begin
                check("desc_strobe_alone", out_desc_wr, 1'b0);
            end
            if (out_cache_valid_wr === 1'b1 && out_cache_valid === 1'b1) commit_seen++;
            if (out_cache_valid_wr === 1'b1 && out_cache_valid === 1'b0) discard_seen++;
            if (out_desc_wr === 1'b1) last_desc = out_desc;
        end
    end

    task automatic drive_word(input logic [1:0] f, input logic [3:0] inv, input logic [4:0] cnt,
                              input logic [7:0] id);
        logic [133:0] w;
        w = {f, inv, $urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
        in_pkt_data_wr    = 1'b1;
        in_pkt_data       = w;
        in_cache_ID_count = cnt;
        in_cache_ID       = id;
        model_word(w, cnt, id, edge_n + 1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            in_pkt_data_wr = 1'b0;
        end
    endtask

    task automatic send_pkt(input int n, input logic [3:0] inv, input logic [4:0] cnt,
                            input logic [7:0] id, input bit with_tail);
        drive_word(H, 4'($urandom), cnt, id);
        for (int i = 1; i < n; i++) begin
            if (i == n - 1) drive_word(with_tail ? T : M, inv, cnt, id);
            else            drive_word(M, 4'($urandom), cnt, id);
        end
    endtask

    // Whatever is on the input bus stays there while reset is high.
    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        model_reset();
        check("rst_data_wr",  out_cache_data_wr,  1'b0);
        check("rst_data",     out_cache_data,     134'h0);
        check("rst_valid_wr", out_cache_valid_wr, 1'b0);
        check("rst_valid",    out_cache_valid,    1'b0);
        check("rst_desc_wr",  out_desc_wr,        1'b0);
        check("rst_desc",     out_desc,           20'h0);
        check("rst_noid",     out_drop_noid_cnt,  0);
        check("rst_long",     out_drop_long_cnt,  0);
        check("rst_fmt",      out_err_fmt_cnt,    0);
        in_pkt_data_wr = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic check_cnts(input string tag, input int noid, input int lng, input int fmt);
        check({tag, "_noid"}, out_drop_noid_cnt, noid);
        check({tag, "_long"}, out_drop_long_cnt, lng);
        check({tag, "_fmt"},  out_err_fmt_cnt,   fmt);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time %0t reached limit 2000000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int b_wr, b_commit, b_discard;
        model_reset();

        // Basic 3-word packet
        apply_reset();
        b_wr = wr_seen; b_commit = commit_seen;
        send_pkt(3, 4'd4, 5'd5, 8'h07, 1'b1);
        idle(3);
        check("t1_writes", wr_seen - b_wr, 3);
        check("t1_commits", commit_seen - b_commit, 1);
        check("t1_desc", last_desc, {8'h07, 12'd44});
        check_cnts("t1", 0, 0, 0);

        // No free ID, then admitted with two free
        apply_reset();
        b_wr = wr_seen; b_commit = commit_seen; b_discard = discard_seen;
        send_pkt(4, 4'd0, 5'd0, 8'h01, 1'b1);
        idle(2);
        check("t2_noid_writes", wr_seen - b_wr, 0);
        check("t2_noid_vld", commit_seen + discard_seen - b_commit - b_discard, 0);
        send_pkt(2, 4'd0, 5'd2, 8'h03, 1'b1);
        idle(3);
        check("t2_commits", commit_seen - b_commit, 1);
        check("t2_desc", last_desc, {8'h03, 12'd32});
        check_cnts("t2", 1, 0, 0);

        // Oversized packet, then exactly MAX_WORDS
        apply_reset();
        b_wr = wr_seen; b_commit = commit_seen; b_discard = discard_seen;
        send_pkt(130, 4'd0, 5'd3, 8'h09, 1'b1);
        idle(3);
        check("t3_long_writes", wr_seen - b_wr, 128);
        check("t3_long_discard", discard_seen - b_discard, 1);
        check("t3_long_commit", commit_seen - b_commit, 0);
        send_pkt(128, 4'd5, 5'd3, 8'h21, 1'b1);
        idle(3);
        check("t3_max_commit", commit_seen - b_commit, 1);
        check("t3_max_desc", last_desc, {8'h21, 12'd2043});
        check_cnts("t3", 0, 1, 0);

        // Missing tail, then stray tail
        apply_reset();
        b_wr = wr_seen; b_commit = commit_seen; b_discard = discard_seen;
        drive_word(H, 4'd0, 5'd4, 8'h11);
        drive_word(M, 4'd0, 5'd4, 8'h11);
        drive_word(H, 4'd0, 5'd4, 8'h12);
        drive_word(M, 4'd0, 5'd4, 8'h12);
        drive_word(T, 4'd3, 5'd4, 8'h12);
        idle(2);
        check("t4_writes", wr_seen - b_wr, 2);
        check("t4_discard", discard_seen - b_discard, 1);
        check("t4_commit", commit_seen - b_commit, 0);
        check_cnts("t4a", 0, 0, 1);
        drive_word(T, 4'd0, 5'd4, 8'h13);
        idle(2);
        check_cnts("t4b", 0, 0, 2);

        // Back-to-back with lagging free count
        apply_reset();
        b_commit = commit_seen;
        send_pkt(2, 4'd0, 5'd1, 8'h05, 1'b1);
        send_pkt(2, 4'd0, 5'd1, 8'h06, 1'b1);
        idle(3);
        check("t5_commits", commit_seen - b_commit, 1);
        check_cnts("t5", 1, 0, 0);
        send_pkt(2, 4'd2, 5'd1, 8'h0a, 1'b1);
        idle(3);
        check("t5_late_commit", commit_seen - b_commit, 2);
        check("t5_desc", last_desc, {8'h0a, 12'd30});

        // Reset while a mid word is on the bus
        apply_reset();
        b_commit = commit_seen; b_discard = discard_seen;
        drive_word(H, 4'd0, 5'd3, 8'h40);
        drive_word(M, 4'd0, 5'd3, 8'h40);
        apply_reset();
        send_pkt(3, 4'd1, 5'd3, 8'h44, 1'b1);
        idle(3);
        check("t6_commit", commit_seen - b_commit, 1);
        check("t6_discard", discard_seen - b_discard, 0);
        check("t6_desc", last_desc, {8'h44, 12'd47});
        check_cnts("t6", 0, 0, 0);

        // Random traffic against the model
        apply_reset();
        for (int p = 0; p < 160; p++) begin
            int kind;
            logic [4:0] cnt;
            logic [7:0] id;
            logic [3:0] inv;
            kind = int'($urandom_range(0, 9));
            cnt  = 5'($urandom_range(0, 3));
            id   = 8'($urandom);
            inv  = 4'($urandom);
            if (kind == 0)      drive_word(($urandom_range(0, 1) == 0) ? M : T, inv, cnt, id);
            else if (kind == 1) send_pkt(int'($urandom_range(2, 6)), inv, cnt, id, 1'b0);
            else if (kind == 2) send_pkt(int'($urandom_range(MAX_WORDS - 2, MAX_WORDS + 3)), inv, cnt, id, 1'b1);
            else                send_pkt(int'($urandom_range(2, 10)), inv, cnt, id, 1'b1);
            if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(1, 3)));
        end
        idle(4);
        check_cnts("rand", m_noid, m_long, m_fmt);
        check("wr_left", exp_wr.size(), 0);
        check("vld_left", exp_vld.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
